imul_idiv_share_arb: RTL and testbench
======================================

// Module: imul_idiv_share_arb
// PURPOSE
//  Shares one iterative RISC-V mul/div unit (MUL..REMU, funct3-selected) among
//  num_req_p requesters, e.g. several vanilla cores or threads on one tile.
//  Round-robin grant; one operation in flight; the result returns to its owner.
//  Sits between the requesters' execute stages and the shared unit's v/ready/yumi ports.
// PARAMETERS
//  width_p    32  operand/result width; must match the shared unit (fixed at 32)
//  num_req_p  4   number of requesters, >=2
//  lg_req_lp  $clog2(num_req_p), localparam: owner-id width
// PORTS
//  clk_i        in   1                    clock
//  reset_i      in   1                    synchronous, active-high reset
//  v_i          in   num_req_p            per-requester request valid
//  ready_o      out  num_req_p            per-requester request accepted (one-hot or 0)
//  opA_i        in   num_req_p*width_p    per-requester rs1 value, requester i at [i*width_p+:width_p]
//  opB_i        in   num_req_p*width_p    per-requester rs2 value
//  funct3_i     in   num_req_p*3          per-requester M-extension funct3
//  v_o          out  num_req_p            result valid, only the owner's bit can be 1
//  result_o     out  width_p              result, broadcast; qualified by v_o
//  yumi_i       in   num_req_p            owner consumes result
//  md_v_o       out  1                    request to shared unit
//  md_ready_i   in   1                    shared unit idle
//  md_opA_o     out  width_p              latched opA
//  md_opB_o     out  width_p              latched opB
//  md_funct3_o  out  3                    latched funct3
//  md_v_i       in   1                    shared unit result valid
//  md_result_i  in   width_p              shared unit result
//  md_yumi_o    out  1                    consume shared unit result
// BEHAVIOUR
//  Reset: state=IDLE, rr pointer=0, owner=0, operand regs=0; ready_o=0, v_o=0,
//   md_v_o=0, md_yumi_o=0. reset_i must also reset the shared unit in the same cycle.
//  FSM: IDLE -> ISSUE -> BUSY -> IDLE.
//   IDLE : grant = round-robin pick among v_i, search starting at rr pointer.
//          ready_o = grant (may depend combinationally on v_i).
//          On any grant: latch opA/opB/funct3 and owner; rr <= owner+1 mod num_req_p; -> ISSUE.
//   ISSUE: md_v_o=1. On md_ready_i -> BUSY. Otherwise hold; operands stay stable.
//   BUSY : v_o[owner]=md_v_i, result_o=md_result_i, md_yumi_o=yumi_i[owner]&md_v_i.
//          On md_yumi_o -> IDLE.
//  Latency: accept in cycle N; md_v_o in N+1; requester sees v_o md-latency cycles after
//   issue. Min accept-to-accept = unit latency + 3 cycles.
//  ready_o=0 outside IDLE, so a second request is never accepted while one is in flight.
//  yumi_i bits of non-owners, and yumi_i without v_o, are ignored.
//  Owner may stall yumi_i indefinitely; the shared unit holds its result (v/yumi semantics).
//  Rotation: a requester holding v_i high waits at most num_req_p-1 grants.
//  Pointer wrap: owner=num_req_p-1 gives rr=0.
//  Only one v_i high: granted regardless of pointer.
//  v_i dropped before grant: no effect, no state change.
//  Unused/illegal funct3 values: passed through unchanged; decode is the unit's job.
//  Mid-operation reset: back to IDLE next cycle; in-flight result discarded; no v_o pulse.
//  Assertions: ready_o and v_o $onehot0; md_v_o only in ISSUE; md_yumi_o implies md_v_i.
// STRUCTURE
//  Shared package (imul_idiv_pkg): state enum {eIDLE,eISSUE,eBUSY}; funct3 width
//   and MD_*_FUN3 constants, shared with the mul/div decode.
//  Sub-module: bsg_arb_round_robin (width_p=num_req_p) gives the grant vector;
//   yumi_i = the IDLE-with-grant pulse. The FSM and operand/owner regs stay in this module.
// TESTING
//  1: req 2 only, MUL 7*-3 -> ready_o=4'b0100 one cycle; v_o=4'b0100, result 0xFFFFFFEB.
//  2: all 4 valid continuously, DIVU 100/7 -> grants in order 0,1,2,3,0; each result 14;
//     rr pointer wraps 3->0.
//  3: owner 1 holds yumi_i low 20 cycles, REMU 100%7 -> v_o stays 4'b0010,
//     result 2 stable, no other ready_o.
//  4: md_ready_i held low 5 cycles during ISSUE -> md_v_o held;
//     md_opA_o/md_opB_o/md_funct3_o unchanged.
//  5: reset_i pulsed in BUSY of DIV 0x80000000/-1 -> next cycle IDLE, v_o=0;
//     next request gets a correct result.
//  6: yumi_i asserted by a non-owner while v_o valid -> ignored; md_yumi_o=0; state stays BUSY.

Source files
------------

// File: rtl/imul_idiv_pkg.sv
// Shared mul/div definitions: FSM states of the share arbiter, funct3 codes of the M extension,
// and the latched operand bundle handed to the shared unit.
package imul_idiv_pkg;

    localparam int MD_WIDTH  = 32;
    localparam int MD_FUN3_W = 3;

    typedef enum logic [1:0] {
        eIDLE  = 2'd0,
        eISSUE = 2'd1,
        eBUSY  = 2'd2
    } md_state_e;

    localparam logic [MD_FUN3_W-1:0] MD_MUL_FUN3    = 3'b000;
    localparam logic [MD_FUN3_W-1:0] MD_MULH_FUN3   = 3'b001;
    localparam logic [MD_FUN3_W-1:0] MD_MULHSU_FUN3 = 3'b010;
    localparam logic [MD_FUN3_W-1:0] MD_MULHU_FUN3  = 3'b011;
    localparam logic [MD_FUN3_W-1:0] MD_DIV_FUN3    = 3'b100;
    localparam logic [MD_FUN3_W-1:0] MD_DIVU_FUN3   = 3'b101;
    localparam logic [MD_FUN3_W-1:0] MD_REM_FUN3    = 3'b110;
    localparam logic [MD_FUN3_W-1:0] MD_REMU_FUN3   = 3'b111;

    typedef struct packed {
        logic [MD_WIDTH-1:0]  op_a;
        logic [MD_WIDTH-1:0]  op_b;
        logic [MD_FUN3_W-1:0] funct3;
    } md_req_t;

endpackage

// File: rtl/bsg_arb_round_robin.sv
// Round-robin arbiter: picks the first requester at or after the pointer.
// Latency: combinational grant; pointer moves the cycle after yumi_i.
// Backpressure: pointer only advances when the winner is consumed via yumi_i.
module bsg_arb_round_robin #(
    parameter  int width_p     = 4,
    localparam int lg_width_lp = (width_p > 1) ? $clog2(width_p) : 1
) (
    input  logic                   clk_i,
    input  logic                   reset_i,
    input  logic [width_p-1:0]     reqs_i,
    output logic [width_p-1:0]     grants_o,
    output logic                   v_o,
    output logic [lg_width_lp-1:0] tag_o,
    input  logic                   yumi_i
);

    logic [lg_width_lp-1:0] rr_r;

    always_comb begin
        int idx;
        idx      = 0;
        grants_o = '0;
        v_o      = 1'b0;
        tag_o    = '0;
        for (int k = 0; k < width_p; k++) begin
            idx = int'(rr_r) + k;
            if (idx >= width_p) idx = idx - width_p;
            if (!v_o && reqs_i[idx]) begin
                v_o           = 1'b1;
                tag_o         = lg_width_lp'(idx);
                grants_o[idx] = 1'b1;
            end
        end
    end

    // The winner drops to lowest priority; the last slot wraps to slot 0.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rr_r <= '0;
        end else if (yumi_i) begin
            rr_r <= (tag_o == lg_width_lp'(width_p - 1)) ? '0 : tag_o + 1'b1;
        end
    end

endmodule

// File: rtl/imul_idiv_share_arb.sv
// Shares one iterative mul/div unit among num_req_p requesters, one op in flight.
// Latency: accept N, md_v_o N+1, result to owner after the unit's latency.
// Backpressure: ready_o low outside IDLE; owner may stall yumi_i, unit holds its result.
module imul_idiv_share_arb
    import imul_idiv_pkg::*;
#(
    parameter  int width_p   = 32,
    parameter  int num_req_p = 4,
    localparam int lg_req_lp = $clog2(num_req_p)
) (
    input  logic                           clk_i,
    input  logic                           reset_i,
    input  logic [num_req_p-1:0]           v_i,
    output logic [num_req_p-1:0]           ready_o,
    input  logic [num_req_p*width_p-1:0]   opA_i,
    input  logic [num_req_p*width_p-1:0]   opB_i,
    input  logic [num_req_p*3-1:0]         funct3_i,
    output logic [num_req_p-1:0]           v_o,
    output logic [width_p-1:0]             result_o,
    input  logic [num_req_p-1:0]           yumi_i,
    output logic                           md_v_o,
    input  logic                           md_ready_i,
    output logic [width_p-1:0]             md_opA_o,
    output logic [width_p-1:0]             md_opB_o,
    output logic [2:0]                     md_funct3_o,
    input  logic                           md_v_i,
    input  logic [width_p-1:0]             md_result_i,
    output logic                           md_yumi_o
);

    md_state_e              state_r;
    logic [lg_req_lp-1:0]   owner_r;
    md_req_t                req_r;
    md_req_t                sel_req;

    logic [num_req_p-1:0]   arb_grants;
    logic                   arb_v;
    logic [lg_req_lp-1:0]   arb_tag;
    logic                   accept;
    logic [num_req_p-1:0]   owner_onehot;

    assign accept = (state_r == eIDLE) && arb_v;

    bsg_arb_round_robin #(
        .width_p (num_req_p)
    ) arb (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .reqs_i   (v_i),
        .grants_o (arb_grants),
        .v_o      (arb_v),
        .tag_o    (arb_tag),
        .yumi_i   (accept)
    );

    always_comb begin
        sel_req        = '0;
        sel_req.op_a   = opA_i[arb_tag*width_p +: width_p];
        sel_req.op_b   = opB_i[arb_tag*width_p +: width_p];
        sel_req.funct3 = funct3_i[arb_tag*3 +: 3];
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_r <= eIDLE;
            owner_r <= '0;
            req_r   <= '0;
        end else begin
            case (state_r)
                eIDLE: begin
                    if (accept) begin
                        state_r <= eISSUE;
                        owner_r <= arb_tag;
                        req_r   <= sel_req;
                    end
                end
                eISSUE: begin
                    if (md_ready_i) state_r <= eBUSY;
                end
                eBUSY: begin
                    if (md_yumi_o) state_r <= eIDLE;
                end
                default: state_r <= eIDLE;
            endcase
        end
    end

    assign owner_onehot = {{(num_req_p-1){1'b0}}, 1'b1} << owner_r;

    assign ready_o     = (state_r == eIDLE) ? arb_grants : '0;
    assign md_v_o      = (state_r == eISSUE);
    assign md_opA_o    = req_r.op_a;
    assign md_opB_o    = req_r.op_b;
    assign md_funct3_o = req_r.funct3;

    // Result path is live only in BUSY; stray yumi from non-owners never reaches the unit.
    assign v_o       = ((state_r == eBUSY) && md_v_i) ? owner_onehot : '0;
    assign result_o  = md_result_i;
    assign md_yumi_o = (state_r == eBUSY) && md_v_i && yumi_i[owner_r];

    a_ready_onehot0: assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(ready_o));
    a_v_onehot0:     assert property (@(posedge clk_i) disable iff (reset_i) $onehot0(v_o));
    a_md_v_issue:    assert property (@(posedge clk_i) disable iff (reset_i) md_v_o |-> (state_r == eISSUE));
    a_md_yumi_v:     assert property (@(posedge clk_i) disable iff (reset_i) md_yumi_o |-> md_v_i);

endmodule

// File: tb/tb_imul_idiv_share_arb.sv
// Bench for the mul/div share arbiter: behavioural shared unit, directed requests, scoreboard monitor.
module tb_imul_idiv_share_arb;
    import imul_idiv_pkg::*;

    localparam int W   = 32;
    localparam int N   = 4;
    localparam int LAT = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [N-1:0]   v_i, ready_o, v_o, yumi_i;
    logic [N*W-1:0] opA_i, opB_i;
    logic [N*3-1:0] funct3_i;
    logic [W-1:0]   result_o, md_opA_o, md_opB_o, md_result_i;
    logic [2:0]     md_funct3_o;
    logic           md_v_o, md_ready_i, md_v_i, md_yumi_o;

    logic [N-1:0]   hold, extra;
    logic           unit_block;
    logic           unit_busy, unit_v;
    int             unit_cnt;
    logic [W-1:0]   unit_res;

    typedef struct {
        int         owner;
        logic [W-1:0] res;
    } exp_t;
    exp_t sbq[$];

    int checks = 0;
    int fails  = 0;

    always #5 clk = ~clk;

    imul_idiv_share_arb #(.width_p(W), .num_req_p(N)) dut (
        .clk_i(clk), .reset_i(reset), .v_i(v_i), .ready_o(ready_o),
        .opA_i(opA_i), .opB_i(opB_i), .funct3_i(funct3_i),
        .v_o(v_o), .result_o(result_o), .yumi_i(yumi_i),
        .md_v_o(md_v_o), .md_ready_i(md_ready_i), .md_opA_o(md_opA_o),
        .md_opB_o(md_opB_o), .md_funct3_o(md_funct3_o), .md_v_i(md_v_i),
        .md_result_i(md_result_i), .md_yumi_o(md_yumi_o)
    );

    function automatic logic [W-1:0] md_calc(input logic [2:0] f, input logic [W-1:0] a, input logic [W-1:0] b);
        logic [63:0] p;
        logic [W-1:0] r;
        r = '0;
        case (f)
            MD_MUL_FUN3:    begin p = {32'b0, a} * {32'b0, b}; r = p[31:0]; end
            MD_MULH_FUN3:   begin p = {{32{a[31]}}, a} * {{32{b[31]}}, b}; r = p[63:32]; end
            MD_MULHSU_FUN3: begin p = {{32{a[31]}}, a} * {32'b0, b}; r = p[63:32]; end
            MD_MULHU_FUN3:  begin p = {32'b0, a} * {32'b0, b}; r = p[63:32]; end
            MD_DIV_FUN3:    r = (b == 0) ? '1 : (a == 32'h8000_0000 && b == '1) ? a : W'($signed(a) / $signed(b));
            MD_DIVU_FUN3:   r = (b == 0) ? '1 : a / b;
            MD_REM_FUN3:    r = (b == 0) ? a : (a == 32'h8000_0000 && b == '1) ? '0 : W'($signed(a) % $signed(b));
            MD_REMU_FUN3:   r = (b == 0) ? a : a % b;
            default:        r = '0;
        endcase
        return r;
    endfunction

    // Shared iterative unit: accepts when idle, result after LAT cycles, held until yumi.
    always @(posedge clk) begin
        if (reset) begin
            unit_busy <= 1'b0;
            unit_v    <= 1'b0;
            unit_cnt  <= 0;
            unit_res  <= '0;
        end else begin
            if (md_v_o && md_ready_i) begin
                unit_busy <= 1'b1;
                unit_cnt  <= LAT;
                unit_res  <= md_calc(md_funct3_o, md_opA_o, md_opB_o);
            end else if (unit_busy) begin
                if (unit_cnt <= 1) begin
                    unit_busy <= 1'b0;
                    unit_v    <= 1'b1;
                end else begin
                    unit_cnt <= unit_cnt - 1;
                end
            end
            if (md_yumi_o) unit_v <= 1'b0;
        end
    end

    assign md_ready_i  = !unit_busy && !unit_v && !unit_block;
    assign md_v_i      = unit_v;
    assign md_result_i = unit_res;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    initial begin
        yumi_i = '0;
        forever begin
            @(negedge clk);
            yumi_i = (v_o & ~hold) | extra;
        end
    end

    // Monitor: every consumed result is compared against the head of the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (!reset && ((v_o & yumi_i) != '0)) begin
                if (sbq.size() == 0) begin
                    checks++;
                    fails++;
                    $display("FAIL unexpected_result: v_o=%b result=0x%08h with empty scoreboard", v_o, result_o);
                end else begin
                    e = sbq.pop_front();
                    chk("result_owner", 32'(v_o), 32'(1) << e.owner);
                    chk("result_value", result_o, e.res);
                end
            end
        end
    end

    task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] f);
        opA_i[idx*W +: W]  = a;
        opB_i[idx*W +: W]  = b;
        funct3_i[idx*3 +: 3] = f;
    endtask

    task automatic issue_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] f, input logic [W-1:0] exp);
        exp_t e;
        int cyc;
        set_req(idx, a, b, f);
        v_i[idx] = 1'b1;
        cyc = 0;
        while (cyc < 100) begin
            #1;
            if (ready_o[idx]) break;
            @(negedge clk);
            cyc++;
        end
        chk("ready_grant", 32'(ready_o), 32'(1) << idx);
        e.owner = idx;
        e.res   = exp;
        sbq.push_back(e);
        @(negedge clk);
        #1;
        chk("ready_one_cycle", 32'(ready_o), 32'(0));
        v_i[idx] = 1'b0;
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while ((sbq.size() != 0 || v_o != '0) && cyc < 300) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("drain_timeout", 32'(cyc < 300), 32'(1));
        @(negedge clk);
    endtask

    task automatic wait_vo(input string name);
        int cyc;
        cyc = 0;
        while (v_o == '0 && cyc < 100) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk(name, 32'(cyc < 100), 32'(1));
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int order[5];
        int gcount, cyc;
        bit ok_v, ok_r, ok_rdy, ok_yumi, ok_a, ok_b, ok_f, ok_mv;
        exp_t e;
        order = '{0, 1, 2, 3, 0};
        reset = 1'b1; v_i = '0; opA_i = '0; opB_i = '0; funct3_i = '0;
        hold = '0; extra = '0; unit_block = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_ready", 32'(ready_o), 32'(0));
        chk("reset_v_o", 32'(v_o), 32'(0));
        chk("reset_md_v", 32'(md_v_o), 32'(0));
        chk("reset_md_yumi", 32'(md_yumi_o), 32'(0));
        chk("reset_md_opA", md_opA_o, 32'(0));
        @(negedge clk);
        reset = 1'b0;

        // Test 1: lone requester 2, MUL 7 * -3
        issue_one(2, 32'd7, 32'hFFFF_FFFD, MD_MUL_FUN3, 32'hFFFF_FFEB);
        wait_drain();

        // Test 2: all requesters valid, grants rotate 0,1,2,3 and wrap to 0
        pulse_reset();
        for (int i = 0; i < N; i++) set_req(i, 32'd100, 32'd7, MD_DIVU_FUN3);
        for (int i = 0; i < 5; i++) begin
            e.owner = order[i];
            e.res   = 32'd14;
            sbq.push_back(e);
        end
        v_i = '1;
        gcount = 0;
        cyc = 0;
        while (gcount < 5 && cyc < 500) begin
            #1;
            if (ready_o != '0) begin
                chk("rr_grant", 32'(ready_o), 32'(1) << order[gcount]);
                gcount++;
            end
            @(negedge clk);
            cyc++;
        end
        v_i = '0;
        chk("rr_grant_count", 32'(gcount), 32'(5));
        wait_drain();

        // Test 3: owner 1 stalls yumi for 20 cycles on REMU 100 % 7
        hold = 4'b0010;
        issue_one(1, 32'd100, 32'd7, MD_REMU_FUN3, 32'd2);
        set_req(0, 32'd3, 32'd4, MD_MUL_FUN3);
        set_req(3, 32'd2, 32'd2, MD_MUL_FUN3);
        wait_vo("stall_wait_v");
        v_i = 4'b1001;
        ok_v = 1; ok_r = 1; ok_rdy = 1; ok_yumi = 1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            #1;
            if (v_o != 4'b0010) ok_v = 0;
            if (result_o != 32'd2) ok_r = 0;
            if (ready_o != '0) ok_rdy = 0;
            if (md_yumi_o) ok_yumi = 0;
        end
        v_i = '0;
        chk("stall_v_o_held", 32'(ok_v), 32'(1));
        chk("stall_result_stable", 32'(ok_r), 32'(1));
        chk("stall_no_ready", 32'(ok_rdy), 32'(1));
        chk("stall_no_md_yumi", 32'(ok_yumi), 32'(1));
        hold = '0;
        wait_drain();

        // Test 4: unit not ready for 5 cycles; issue must hold with stable operands
        unit_block = 1'b1;
        issue_one(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, MD_MULHU_FUN3, 32'hFFFF_FFFE);
        set_req(0, 32'h1234_5678, 32'h0000_0009, MD_REM_FUN3);
        ok_mv = 1; ok_a = 1; ok_b = 1; ok_f = 1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            if (!md_v_o) ok_mv = 0;
            if (md_opA_o != 32'hFFFF_FFFF) ok_a = 0;
            if (md_opB_o != 32'hFFFF_FFFF) ok_b = 0;
            if (md_funct3_o != MD_MULHU_FUN3) ok_f = 0;
        end
        chk("issue_md_v_held", 32'(ok_mv), 32'(1));
        chk("issue_opA_stable", 32'(ok_a), 32'(1));
        chk("issue_opB_stable", 32'(ok_b), 32'(1));
        chk("issue_funct3_stable", 32'(ok_f), 32'(1));
        unit_block = 1'b0;
        wait_drain();

        // Test 6: non-owner yumi while owner 3 holds its result
        hold = 4'b1000;
        issue_one(3, 32'd5, 32'd6, MD_MUL_FUN3, 32'd30);
        wait_vo("stray_wait_v");
        extra = 4'b0101;
        @(negedge clk);
        ok_v = 1; ok_yumi = 1; ok_r = 1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (v_o != 4'b1000) ok_v = 0;
            if (md_yumi_o) ok_yumi = 0;
            if (result_o != 32'd30) ok_r = 0;
        end
        chk("stray_yumi_v_o_held", 32'(ok_v), 32'(1));
        chk("stray_yumi_no_md_yumi", 32'(ok_yumi), 32'(1));
        chk("stray_yumi_result", 32'(ok_r), 32'(1));
        extra = '0;
        hold  = '0;
        wait_drain();

        // Test 5: reset while BUSY on DIV overflow; result discarded, next ops correct
        issue_one(1, 32'h8000_0000, 32'hFFFF_FFFF, MD_DIV_FUN3, 32'h8000_0000);
        cyc = 0;
        while (md_v_o && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        chk("busy_reached", 32'(cyc < 50), 32'(1));
        @(negedge clk);
        reset = 1'b1;
        sbq.delete();
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midreset_v_o", 32'(v_o), 32'(0));
        chk("midreset_md_v", 32'(md_v_o), 32'(0));
        chk("midreset_ready", 32'(ready_o), 32'(0));
        ok_v = 1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            #1;
            if (v_o != '0) ok_v = 0;
        end
        chk("midreset_no_v_pulse", 32'(ok_v), 32'(1));
        @(negedge clk);
        issue_one(1, 32'h8000_0000, 32'hFFFF_FFFF, MD_DIV_FUN3, 32'h8000_0000);
        wait_drain();
        issue_one(2, 32'h8000_0000, 32'hFFFF_FFFF, MD_REM_FUN3, 32'h0000_0000);
        wait_drain();

        chk("scoreboard_empty", 32'(sbq.size()), 32'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
